// File: rtl/score_pkg.sv
// Shared types and constants for the match score controller.
package score_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] HARD_CAP = DIGIT_W'(9);

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_PAUSE = 2'd1,
        ST_OVER  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE  = 2'b00,
        WIN_LEFT  = 2'b01,
        WIN_RIGHT = 2'b10
    } winner_e;

    // Score increment that never passes the display's single-digit cap.
    function automatic logic [DIGIT_W-1:0] sat_inc(input logic [DIGIT_W-1:0] d);
        return (d >= HARD_CAP) ? HARD_CAP : d + DIGIT_W'(1);
    endfunction

endpackage

// File: rtl/frame_pause_timer.sv
// Post-goal freeze counter: loaded on a goal, counts down on frame pulses,
// flags the frame pulse on which it reaches zero.
module frame_pause_timer #(
    parameter int unsigned PAUSE_FRAMES = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic clear_i,
    input  logic sof_i,
    output logic done_c_o
);

    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CNT_W'(PAUSE_FRAMES);
        end else if (sof_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_c_o = sof_i && (cnt_q == CNT_W'(1)) && !clear_i && !load_i;

endmodule

// File: rtl/match_score_controller.sv
// Pong match scoring: goal edge detection, round-robin arbitration, pause and
// game-over control. Define WIN_BY_TWO_EN to require a two-point lead to win.
module match_score_controller
    import score_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = 5,
    parameter int unsigned PAUSE_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               goalLeft,
    input  logic               goalRight,
    input  logic               newGame,
    output logic [DIGIT_W-1:0] digitLeft,
    output logic [DIGIT_W-1:0] digitRight,
    output logic               scoreLevel1,
    output logic               scoreLevel2,
    output logic               freezeBall,
    output logic               ballRestart,
    output logic               gameOver,
    output logic [1:0]         winner
);

    localparam logic [DIGIT_W-1:0] WIN_D = DIGIT_W'(WIN_SCORE);

    state_e             state_q, state_d;
    winner_e            winner_q, winner_d;
    logic [DIGIT_W-1:0] dl_q, dl_d, dr_q, dr_d;
    logic               tok_q, tok_d;
    logic               gl_q, gr_q;
    logic               sl1_q, sl1_d, sl2_q, sl2_d;
    logic               br_q, br_d;
    logic               frz_q, over_q;

    logic               ev_l, ev_r, grant_l, grant_r;
    logic [DIGIT_W-1:0] inc_l, inc_r;
    logic               lead_l, lead_r, end_l, end_r;
    logic               tmr_load, tmr_clear, tmr_done;

    frame_pause_timer #(
        .PAUSE_FRAMES(PAUSE_FRAMES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load_i  (tmr_load),
        .clear_i (tmr_clear),
        .sof_i   (startOfFrame),
        .done_c_o(tmr_done)
    );

    assign ev_l    = goalLeft  && !gl_q;
    assign ev_r    = goalRight && !gr_q;
    // Token 0 favours left on a tie, 1 favours right.
    assign grant_l = ev_l && (!ev_r || !tok_q);
    assign grant_r = ev_r && (!ev_l ||  tok_q);
    assign inc_l   = sat_inc(dl_q);
    assign inc_r   = sat_inc(dr_q);

`ifdef WIN_BY_TWO_EN
    assign lead_l = {1'b0, inc_l} >= ({1'b0, dr_q} + 5'd2);
    assign lead_r = {1'b0, inc_r} >= ({1'b0, dl_q} + 5'd2);
`else
    assign lead_l = 1'b1;
    assign lead_r = 1'b1;
`endif

    assign end_l = ((inc_l >= WIN_D) && lead_l) || (inc_l == HARD_CAP);
    assign end_r = ((inc_r >= WIN_D) && lead_r) || (inc_r == HARD_CAP);

    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        dl_d      = dl_q;
        dr_d      = dr_q;
        tok_d     = tok_q;
        sl1_d     = 1'b0;
        sl2_d     = 1'b0;
        br_d      = 1'b0;
        tmr_load  = 1'b0;
        tmr_clear = 1'b0;

        if (newGame) begin
            state_d   = ST_PLAY;
            winner_d  = WIN_NONE;
            dl_d      = '0;
            dr_d      = '0;
            tok_d     = 1'b0;
            br_d      = 1'b1;
            tmr_clear = 1'b1;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (ev_l && ev_r) begin
                        tok_d = !tok_q;
                    end
                    if (grant_l) begin
                        dl_d  = inc_l;
                        sl1_d = 1'b1;
                        if (end_l) begin
                            state_d  = ST_OVER;
                            winner_d = WIN_LEFT;
                        end else begin
                            state_d  = ST_PAUSE;
                            tmr_load = 1'b1;
                        end
                    end else if (grant_r) begin
                        dr_d  = inc_r;
                        sl2_d = 1'b1;
                        if (end_r) begin
                            state_d  = ST_OVER;
                            winner_d = WIN_RIGHT;
                        end else begin
                            state_d  = ST_PAUSE;
                            tmr_load = 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (tmr_done) begin
                        br_d    = 1'b1;
                        state_d = ST_PLAY;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_PLAY;
            winner_q <= WIN_NONE;
            dl_q     <= '0;
            dr_q     <= '0;
            tok_q    <= 1'b0;
            gl_q     <= 1'b0;
            gr_q     <= 1'b0;
            sl1_q    <= 1'b0;
            sl2_q    <= 1'b0;
            br_q     <= 1'b0;
            frz_q    <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            dl_q     <= dl_d;
            dr_q     <= dr_d;
            tok_q    <= tok_d;
            gl_q     <= goalLeft;
            gr_q     <= goalRight;
            sl1_q    <= sl1_d;
            sl2_q    <= sl2_d;
            br_q     <= br_d;
            frz_q    <= (state_d != ST_PLAY);
            over_q   <= (state_d == ST_OVER);
        end
    end

    assign digitLeft   = dl_q;
    assign digitRight  = dr_q;
    assign scoreLevel1 = sl1_q;
    assign scoreLevel2 = sl2_q;
    assign freezeBall  = frz_q;
    assign ballRestart = br_q;
    assign gameOver    = over_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_match_score_controller.sv
// Self-checking bench for match_score_controller: directed scenarios plus a
// randomized run against a frame-level behavioural model of the match rules.
module tb_match_score_controller;

    localparam int WIN = 5;
    localparam int PF  = 60;

    logic       clk = 1'b0;
    logic       reset, startOfFrame, goalLeft, goalRight, newGame;
    logic [3:0] digitLeft, digitRight;
    logic       scoreLevel1, scoreLevel2, freezeBall, ballRestart, gameOver;
    logic [1:0] winner;

    int checks = 0;
    int errors = 0;

    match_score_controller #(.WIN_SCORE(WIN), .PAUSE_FRAMES(PF)) dut (
        .clk         (clk),
        .reset       (reset),
        .startOfFrame(startOfFrame),
        .goalLeft    (goalLeft),
        .goalRight   (goalRight),
        .newGame     (newGame),
        .digitLeft   (digitLeft),
        .digitRight  (digitRight),
        .scoreLevel1 (scoreLevel1),
        .scoreLevel2 (scoreLevel2),
        .freezeBall  (freezeBall),
        .ballRestart (ballRestart),
        .gameOver    (gameOver),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    // Reference model: match phase, scores, tie-break owner, frames left.
    localparam int PH_PLAY = 0, PH_PAUSE = 1, PH_OVER = 2;
    int m_phase, m_l, m_r, m_win, m_frames;
    bit m_tok_right, m_prev_l, m_prev_r, m_s1, m_s2, m_br;

    function automatic bit match_ends(int mine, int theirs);
`ifdef WIN_BY_TWO_EN
        return (mine >= WIN && mine - theirs >= 2) || mine == 9;
`else
        return (mine >= WIN) || mine == 9 || (theirs < 0);
`endif
    endfunction

    task automatic model_step();
        bit evl, evr, left_gets;
        evl = goalLeft && !m_prev_l;
        evr = goalRight && !m_prev_r;
        m_s1 = 0; m_s2 = 0; m_br = 0;
        if (reset) begin
            m_phase = PH_PLAY; m_l = 0; m_r = 0; m_win = 0; m_frames = 0;
            m_tok_right = 0; m_prev_l = 0; m_prev_r = 0;
            return;
        end
        m_prev_l = goalLeft;
        m_prev_r = goalRight;
        if (newGame) begin
            m_phase = PH_PLAY; m_l = 0; m_r = 0; m_win = 0; m_frames = 0;
            m_tok_right = 0; m_br = 1;
            return;
        end
        if (m_phase == PH_PLAY && (evl || evr)) begin
            left_gets = evl && (!evr || !m_tok_right);
            if (evl && evr) m_tok_right = !m_tok_right;
            if (left_gets) begin
                if (m_l < 9) m_l++;
                m_s1 = 1;
                if (match_ends(m_l, m_r)) begin m_phase = PH_OVER; m_win = 1; end
                else begin m_phase = PH_PAUSE; m_frames = PF; end
            end else begin
                if (m_r < 9) m_r++;
                m_s2 = 1;
                if (match_ends(m_r, m_l)) begin m_phase = PH_OVER; m_win = 2; end
                else begin m_phase = PH_PAUSE; m_frames = PF; end
            end
        end else if (m_phase == PH_PAUSE && startOfFrame) begin
            m_frames--;
            if (m_frames == 0) begin m_br = 1; m_phase = PH_PLAY; end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frames(int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1; tick();
            startOfFrame = 0; tick(); tick();
        end
    endtask

    task automatic test_reset();
        reset = 1; startOfFrame = 0; goalLeft = 0; goalRight = 0; newGame = 0;
        tick(); tick();
        checks++; if (digitLeft !== 4'd0 || digitRight !== 4'd0) begin errors++;
            $display("FAIL reset_digits got %0d-%0d want 0-0", digitLeft, digitRight); end
        checks++; if ({scoreLevel1, scoreLevel2, ballRestart} !== 3'b000) begin errors++;
            $display("FAIL reset_pulses got %b want 000", {scoreLevel1, scoreLevel2, ballRestart}); end
        checks++; if ({freezeBall, gameOver, winner} !== 4'b0000) begin errors++;
            $display("FAIL reset_status got %b want 0000", {freezeBall, gameOver, winner}); end
        reset = 0; tick();
    endtask

    task automatic test_goal_pause();
        goalLeft = 1; tick();
        checks++; if (digitLeft !== 4'd1 || scoreLevel1 !== 1'b1 || freezeBall !== 1'b1) begin errors++;
            $display("FAIL goal_credit got dl=%0d sl1=%b frz=%b want 1 1 1", digitLeft, scoreLevel1, freezeBall); end
        goalLeft = 0; tick();
        checks++; if (scoreLevel1 !== 1'b0) begin errors++;
            $display("FAIL goal_pulse_len got %b want 0", scoreLevel1); end
        for (int n = 1; n <= PF; n++) begin
            startOfFrame = 1; tick(); startOfFrame = 0;
            checks++; if (ballRestart !== (n == PF)) begin errors++;
                $display("FAIL restart_frame_%0d got %b want %b", n, ballRestart, (n == PF)); end
            tick(); tick();
        end
        checks++; if (freezeBall !== 1'b0 || ballRestart !== 1'b0) begin errors++;
            $display("FAIL pause_exit got frz=%b br=%b want 0 0", freezeBall, ballRestart); end
    endtask

    task automatic test_held_goal();
        newGame = 1; tick(); newGame = 0; tick();
        goalLeft = 1;
        run_frames(200);
        checks++; if (digitLeft !== 4'd1 || digitRight !== 4'd0) begin errors++;
            $display("FAIL held_goal got %0d-%0d want 1-0", digitLeft, digitRight); end
        goalLeft = 0; tick();
    endtask

    task automatic test_simultaneous();
        newGame = 1; tick(); newGame = 0; tick();
        goalLeft = 1; goalRight = 1; tick();
        checks++; if (digitLeft !== 4'd1 || digitRight !== 4'd0 || scoreLevel2 !== 1'b0) begin errors++;
            $display("FAIL simul_first got %0d-%0d sl2=%b want 1-0 0", digitLeft, digitRight, scoreLevel2); end
        goalLeft = 0; goalRight = 0;
        run_frames(PF);
        goalLeft = 1; goalRight = 1; tick();
        checks++; if (digitLeft !== 4'd1 || digitRight !== 4'd1 || scoreLevel2 !== 1'b1) begin errors++;
            $display("FAIL simul_second got %0d-%0d sl2=%b want 1-1 1", digitLeft, digitRight, scoreLevel2); end
        goalLeft = 0; goalRight = 0;
        run_frames(PF);
    endtask

    task automatic test_win();
        newGame = 1; tick(); newGame = 0; tick();
        for (int i = 1; i <= WIN; i++) begin
            goalLeft = 1; tick(); goalLeft = 0;
            checks++; if (digitLeft !== 4'(i)) begin errors++;
                $display("FAIL win_step_%0d got %0d want %0d", i, digitLeft, i); end
            if (i < WIN) run_frames(PF);
        end
        checks++; if (gameOver !== 1'b1 || winner !== 2'b01 || freezeBall !== 1'b1) begin errors++;
            $display("FAIL win_over got go=%b w=%b frz=%b want 1 01 1", gameOver, winner, freezeBall); end
        tick();
        goalRight = 1; tick(); goalRight = 0;
        checks++; if (scoreLevel2 !== 1'b0 || digitRight !== 4'd0) begin errors++;
            $display("FAIL over_ignore got sl2=%b dr=%0d want 0 0", scoreLevel2, digitRight); end
        run_frames(PF + 5);
        checks++; if (gameOver !== 1'b1 || digitLeft !== 4'(WIN) || ballRestart !== 1'b0) begin errors++;
            $display("FAIL over_hold got go=%b dl=%0d br=%b want 1 %0d 0", gameOver, digitLeft, ballRestart, WIN); end
    endtask

    task automatic test_restart();
        newGame = 1; goalRight = 1; tick(); newGame = 0; goalRight = 0;
        checks++; if (digitLeft !== 4'd0 || digitRight !== 4'd0 || winner !== 2'b00) begin errors++;
            $display("FAIL restart_clear got %0d-%0d w=%b want 0-0 00", digitLeft, digitRight, winner); end
        checks++; if ({ballRestart, scoreLevel2, gameOver, freezeBall} !== 4'b1000) begin errors++;
            $display("FAIL restart_flags got %b want 1000", {ballRestart, scoreLevel2, gameOver, freezeBall}); end
        tick();
    endtask

    task automatic test_win_by_two();
        newGame = 1; tick(); newGame = 0; tick();
        for (int i = 0; i < 4; i++) begin
            goalLeft = 1; tick(); goalLeft = 0; run_frames(PF);
            goalRight = 1; tick(); goalRight = 0; run_frames(PF);
        end
        checks++; if (digitLeft !== 4'd4 || digitRight !== 4'd4) begin errors++;
            $display("FAIL tie_44 got %0d-%0d want 4-4", digitLeft, digitRight); end
        goalLeft = 1; tick(); goalLeft = 0;
`ifdef WIN_BY_TWO_EN
        checks++; if (digitLeft !== 4'd5 || gameOver !== 1'b0) begin errors++;
            $display("FAIL wb2_54 got dl=%0d go=%b want 5 0", digitLeft, gameOver); end
        run_frames(PF);
        goalLeft = 1; tick(); goalLeft = 0;
        checks++; if (digitLeft !== 4'd6 || gameOver !== 1'b1 || winner !== 2'b01) begin errors++;
            $display("FAIL wb2_64 got dl=%0d go=%b w=%b want 6 1 01", digitLeft, gameOver, winner); end
`else
        checks++; if (digitLeft !== 4'd5 || gameOver !== 1'b1 || winner !== 2'b01) begin errors++;
            $display("FAIL win_54 got dl=%0d go=%b w=%b want 5 1 01", digitLeft, gameOver, winner); end
`endif
        tick();
    endtask

    task automatic test_reset_mid_pause();
        newGame = 1; tick(); newGame = 0; tick();
        goalRight = 1; tick(); goalRight = 0;
        run_frames(PF - 1);
        reset = 1; startOfFrame = 1; tick(); startOfFrame = 0;
        checks++; if (ballRestart !== 1'b0 || freezeBall !== 1'b0 || digitRight !== 4'd0) begin errors++;
            $display("FAIL reset_pause got br=%b frz=%b dr=%0d want 0 0 0", ballRestart, freezeBall, digitRight); end
        reset = 0; tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 29) == 0) goalLeft = ~goalLeft;
            if ($urandom_range(0, 29) == 0) goalRight = ~goalRight;
            if ($urandom_range(0, 59) == 0) begin goalLeft = 1; goalRight = 1; end
            startOfFrame = ($urandom_range(0, 2) == 0);
            newGame = ($urandom_range(0, 599) == 0);
            reset = ($urandom_range(0, 2999) == 0);
            tick();
            checks++; if (digitLeft !== 4'(m_l) || digitRight !== 4'(m_r)) begin errors++;
                $display("FAIL rnd_digits cyc %0d got %0d-%0d want %0d-%0d", i, digitLeft, digitRight, m_l, m_r); end
            checks++; if ({scoreLevel1, scoreLevel2, ballRestart} !== {m_s1, m_s2, m_br}) begin errors++;
                $display("FAIL rnd_pulses cyc %0d got %b want %b", i, {scoreLevel1, scoreLevel2, ballRestart}, {m_s1, m_s2, m_br}); end
            checks++; if (freezeBall !== (m_phase != PH_PLAY) || gameOver !== (m_phase == PH_OVER) || winner !== 2'(m_win)) begin errors++;
                $display("FAIL rnd_status cyc %0d got frz=%b go=%b w=%b want %b %b %0d", i, freezeBall, gameOver, winner,
                         (m_phase != PH_PLAY), (m_phase == PH_OVER), m_win); end
        end
        reset = 0; newGame = 0; startOfFrame = 0; goalLeft = 0; goalRight = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_goal_pause();
        test_held_goal();
        test_simultaneous();
        test_win();
        test_restart();
        test_win_by_two();
        test_reset_mid_pause();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/match_score_controller.md
MATCH_SCORE_CONTROLLER -- requirements
Module: match_score_controller

Interface
REQ-001 SHALL have parameter WIN_SCORE: default 5; score that ends the match (legal range 1..9).
REQ-002 SHALL have parameter PAUSE_FRAMES: default 60; frames the ball is frozen after a goal (legal range 1..255).
REQ-003 SHALL have input clk, 1 bit; the only clock.
REQ-004 SHALL have input reset, 1 bit; synchronous, active-high.
REQ-005 SHALL have input startOfFrame, 1 bit; one-cycle pulse per video frame.
REQ-006 SHALL have input goalLeft, 1 bit; level input, high while the ball is in the right goal (left player scores).
REQ-007 SHALL have input goalRight, 1 bit; level input, high while the ball is in the left goal (right player scores).
REQ-008 SHALL have input newGame, 1 bit; one-cycle restart request.
REQ-009 SHALL have output digitLeft, 4 bits; left player's score, 0..9, feeds the score display.
REQ-010 SHALL have output digitRight, 4 bits; right player's score, 0..9.
REQ-011 SHALL have outputs scoreLevel1 and scoreLevel2, 1 bit each; one-cycle pulse when left or right is credited.
REQ-012 SHALL have output freezeBall, 1 bit; high in PAUSE and OVER.
REQ-013 SHALL have output ballRestart, 1 bit; one-cycle pulse telling the ball to re-serve from centre.
REQ-014 SHALL have output gameOver, 1 bit; high in OVER.
REQ-015 SHALL have output winner, 2 bits; 00 none, 01 left, 10 right.

Function
REQ-016 SHALL implement states PLAY, PAUSE and OVER, all outputs registered.
REQ-017 SHALL register each goal input every cycle in all states; a goal event is input=1 with previous sample=0, so a held level never re-triggers.
REQ-018 In PLAY, a goal event in cycle n SHALL make the score, pulse and state updates visible in cycle n+1.
REQ-019 On simultaneous left and right events, SHALL grant the side holding a round-robin token, drop the other and toggle the token; the token resets to left, and a single event does not change it.
REQ-020 A granted goal SHALL increment that digit, saturating at 9, and pulse the matching scoreLevel output.
REQ-021 After a granted goal, SHALL go to OVER if the match-end rule holds on the new scores, else to PAUSE with the frame counter loaded with PAUSE_FRAMES.
REQ-022 Match-end rule: the granted side's new score >= WIN_SCORE, or the new score == 9 (hard cap).
REQ-023 In PAUSE, SHALL decrement the counter on each startOfFrame; on the startOfFrame where it reaches 0, SHALL pulse ballRestart and return to PLAY.
REQ-024 Goal events in PAUSE and OVER SHALL be ignored, without credit and without token change.
REQ-025 In OVER, SHALL hold the scores and winner and keep gameOver=1 and freezeBall=1.
REQ-026 newGame in any state SHALL clear the digits, winner and token, pulse ballRestart and go to PLAY next cycle.
REQ-027 newGame SHALL take precedence over a goal event or startOfFrame in the same cycle.

Reset
REQ-028 When reset=1 at a clk edge, SHALL enter PLAY and clear digits, counter, winner, token (to left) and edge registers to 0.
REQ-029 During reset, all pulse outputs, freezeBall and gameOver SHALL be 0.
REQ-030 Reset mid-PAUSE or mid-OVER SHALL abandon the state without emitting ballRestart.

Configuration
REQ-031 With macro WIN_BY_TWO_EN defined, the match-end rule SHALL become: (new score >= WIN_SCORE and lead >= 2) or new score == 9.
REQ-032 Without WIN_BY_TWO_EN, the rule of REQ-022 applies unchanged.

Structure
REQ-033 Package score_pkg SHALL hold the state enum, the winner codes (NONE/LEFT/RIGHT), the digit width constant (4) and the hard cap constant (9).
REQ-034 The frame counter SHALL be sub-module frame_pause_timer (load, startOfFrame, done pulse).

Verification
REQ-035 Goal-and-pause scenario: from reset, goalLeft rises once -> next cycle digitLeft=1 and scoreLevel1 pulses; freezeBall high; ballRestart exactly at the 60th startOfFrame.
REQ-036 Held-goal scenario: goalLeft held high for 200 frames across the pause -> only one credit, digitLeft=1.
REQ-037 Simultaneous-goal scenario: goalLeft and goalRight rise together twice, each in PLAY -> first credits left (1-0), second credits right (1-1).
REQ-038 Win scenario, WIN_SCORE=5, macro off: left reaches 5 -> gameOver=1, winner=01; further goals are ignored.
REQ-039 Win-by-two scenario, macro on, scores 4-4: left scores -> 5-4 and no OVER; left scores again -> 6-4, gameOver=1.
REQ-040 Restart scenario: newGame and goalRight coincide in OVER -> digits 0-0, winner=00, ballRestart pulse, PLAY, no credit.
